// File: rtl/n_serial_sub.sv
// n_serial_sub: bit-serial subtractor producing one difference bit per cycle, LSB first,
// with a valid/ready handshake on both sides. Define N_SERIAL_SUB_OVERFLOW_EN to add the signed overflow flag.
module n_serial_sub #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_1,
    input  logic [SIZE-1:0] in_2,
    input  logic            borrow_in,
    output logic [SIZE-1:0] diff,
    output logic            borrow_out,
`ifdef N_SERIAL_SUB_OVERFLOW_EN
    output logic            overflow,
`endif
    output logic            out_valid,
    input  logic            out_ready
);
    localparam int CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SIZE - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic [SIZE-1:0]   a_q, b_q;
    logic              br_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              bit_a, bit_b, bit_d, br_nxt, last_bit;
    logic [SIZE:0]     diff_ext;

    function automatic logic sub_diff(input logic a, input logic b, input logic br);
        return a ^ b ^ br;
    endfunction

    function automatic logic sub_borrow(input logic a, input logic b, input logic br);
        return (~a & b) | (~(a ^ b) & br);
    endfunction

    assign bit_a    = a_q[0];
    assign bit_b    = b_q[0];
    assign bit_d    = sub_diff(bit_a, bit_b, br_q);
    assign br_nxt   = sub_borrow(bit_a, bit_b, br_q);
    assign last_bit = (cnt_q == LAST);
    // New bit enters at the MSB; after SIZE shifts bit 0 has reached diff[0].
    assign diff_ext = {bit_d, diff};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            br_q       <= 1'b0;
            cnt_q      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef N_SERIAL_SUB_OVERFLOW_EN
            overflow   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= in_1;
                        b_q   <= in_2;
                        br_q  <= borrow_in;
                        cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    br_q  <= br_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    diff  <= diff_ext[SIZE:1];
                    if (last_bit) begin
                        borrow_out <= br_nxt;
`ifdef N_SERIAL_SUB_OVERFLOW_EN
                        // On the last bit the operand LSBs are the original sign bits.
                        overflow   <= (bit_a ^ bit_b) & (bit_d ^ bit_a);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/n_serial_sub.md
N_SERIAL_SUB -- requirements
Module: n_serial_sub

Interface
REQ-001 SHALL have parameter SIZE, default 4, meaning operand and difference width in bits (legal range 1..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operands and borrow_in are valid.
REQ-005 SHALL have port in_ready  output  1  block accepts a new operation.
REQ-006 SHALL have port in_1  input  SIZE  minuend, unsigned or two's complement.
REQ-007 SHALL have port in_2  input  SIZE  subtrahend.
REQ-008 SHALL have port borrow_in  input  1  incoming borrow, subtracted at bit 0.
REQ-009 SHALL have port diff  output  SIZE  result in_1 - in_2 - borrow_in, modulo 2^SIZE.
REQ-010 SHALL have port borrow_out  output  1  borrow out of the MSB (1 when in_1 < in_2 + borrow_in, unsigned).
REQ-011 SHALL have port out_valid  output  1  diff and borrow_out are valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 SHALL capture in_1, in_2 and borrow_in, clear the bit counter and enter SHIFT on any edge with in_valid & in_ready.
REQ-016 SHALL ignore in_valid, in_1, in_2 and borrow_in outside IDLE.
REQ-017 SHALL compute one bit per SHIFT cycle, LSB first: d = a ^ b ^ br; br_next = (~a & b) | (~(a ^ b) & br), with br seeded from borrow_in.
REQ-018 SHALL shift d into diff from the MSB side, so that after SIZE bits diff[0] holds bit 0.
REQ-019 SHALL remain in SHIFT for exactly SIZE cycles, then enter DONE with borrow_out = final br.
REQ-020 SHALL give this latency: handshake in cycle 0, bits in cycles 1..SIZE, out_valid = 1 from cycle SIZE+1.
REQ-021 SHALL hold diff, borrow_out and out_valid stable in DONE while out_ready = 0, with no cycle limit.
REQ-022 SHALL return to IDLE on an edge with out_valid & out_ready, leaving diff and borrow_out unchanged until the next capture.
REQ-023 SHALL NOT accept a new operation in the cycle the result is consumed; in_ready rises one cycle later (throughput one result per SIZE+2 cycles).
REQ-024 SHALL handle SIZE = 1: exactly one SHIFT cycle, out_valid in cycle 2.

Reset
REQ-025 SHALL, on any edge with rst = 1 and in any state, enter IDLE and clear diff, borrow_out, the internal operand registers, the borrow state and the bit counter.
REQ-026 SHALL, after reset, output in_ready = 1, out_valid = 0, diff = 0 and borrow_out = 0 (overflow = 0 when present).
REQ-027 SHALL give rst priority over every handshake in the same cycle and discard an operation aborted mid-SHIFT.

Configuration
REQ-028 SHALL, when macro N_SERIAL_SUB_OVERFLOW_EN is defined, add port overflow  output  1 = (in_1[MSB] != in_2[MSB]) & (diff[MSB] != in_1[MSB]), registered with borrow_out, valid and held under the same rules.
REQ-029 SHALL, without N_SERIAL_SUB_OVERFLOW_EN, omit the overflow port and all of its logic; all other behaviour stays identical.

Verification (SIZE = 4 unless stated)
REQ-030 SHALL check a basic subtract: in_1 = 9, in_2 = 5, borrow_in = 0, handshake in cycle 0 -> out_valid in cycle 5, diff = 4, borrow_out = 0.
REQ-031 SHALL check the underflow wrap-around: in_1 = 3, in_2 = 5 -> diff = 14, borrow_out = 1; and in_1 = 0, in_2 = 0, borrow_in = 1 -> diff = 15, borrow_out = 1.
REQ-032 SHALL check backpressure: out_ready = 0 for 3 cycles after out_valid -> diff, borrow_out and out_valid held, in_ready = 0, in_valid pulses ignored; out_ready = 1 -> IDLE next cycle.
REQ-033 SHALL check reset mid-operation: rst in cycle 2 of SHIFT -> next cycle in_ready = 1, out_valid = 0, diff = 0; a fresh 7 - 2 then yields diff = 5.
REQ-034 SHALL, with N_SERIAL_SUB_OVERFLOW_EN, check in_1 = 8 (-8), in_2 = 1 -> diff = 7, overflow = 1, borrow_out = 0; and in_1 = 6, in_2 = 2 -> overflow = 0.
REQ-035 SHALL, with SIZE = 1, check in_1 = 0, in_2 = 1 -> out_valid in cycle 2, diff = 1, borrow_out = 1.
